// File: rtl/uks_channel_demux_pkg.sv
// ============================================================================
// uks_channel_demux_pkg : shared widths, defaults and decode types (rev 1.0)
// ============================================================================
`default_nettype none

package uks_channel_demux_pkg;

    localparam int MSB_DATA  = 15;
    localparam int MSB_ADDR  = 7;
    localparam int MSB_TIMER = 31;
    localparam int MSB_LED   = 4;

    localparam int ONE_CNT_OPER    = 500_000;
    localparam int DEF_N_CH        = 16;
    localparam int DEF_ADDR_W      = MSB_ADDR + 1;
    localparam int DEF_TICK_CYCLES = ONE_CNT_OPER;
    localparam logic [MSB_ADDR:0] DEF_BCAST_ADDR = '1;

    localparam int LED_HB    = 0;
    localparam int LED_STALE = 1;
    localparam int LED_ERR   = 2;

    localparam int ERR_CNT_W = 8;
    localparam int AGE_W     = 16;

    // A single channel still needs a one-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_IDX_W = ch_idx_w(DEF_N_CH);

    typedef enum logic [1:0] {
        DEC_NONE  = 2'd0,
        DEC_CHAN  = 2'd1,
        DEC_BCAST = 2'd2,
        DEC_ERR   = 2'd3
    } dec_kind_e;

endpackage

`default_nettype wire

// File: rtl/uks_channel_demux_if.sv
// ============================================================================
// uks_channel_demux_if : addressed-word valid/ready bus (rev 1.0)
// ============================================================================
`default_nettype none

interface uks_channel_demux_if
    import uks_channel_demux_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = MSB_DATA + 1
) ();

    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_addr, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_addr, input  s_data, output s_ready);

endinterface

`default_nettype wire

// File: rtl/uks_tick_gen.sv
// ============================================================================
// uks_tick_gen : free-running tick, one pulse every TICK_CYCLES clocks (rev 1.0)
// ============================================================================
`default_nettype none

module uks_tick_gen
    import uks_channel_demux_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [MSB_TIMER:0] C_LAST = (MSB_TIMER + 1)'(TICK_CYCLES - 1);
    localparam logic [MSB_TIMER:0] C_ONE  = (MSB_TIMER + 1)'(1);

    logic [MSB_TIMER:0] r_cnt;

    assign tick = (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uks_channel_demux.sv
// ============================================================================
// uks_channel_demux : routes addressed words to N_CH holding registers (rev 1.0)
// ============================================================================
`default_nettype none

module uks_channel_demux
    import uks_channel_demux_pkg::*;
#(
    parameter int                N_CH          = DEF_N_CH,
    parameter int                DATA_W        = MSB_DATA + 1,
    parameter int                ADDR_W        = MSB_ADDR + 1,
    parameter int                CH_BASE       = 0,
    parameter logic [ADDR_W-1:0] BCAST_ADDR    = '1,
    parameter int                TICK_CYCLES   = DEF_TICK_CYCLES,
    parameter int                TIMEOUT_TICKS = 100,
    parameter int                LED_W         = MSB_LED + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    uks_channel_demux_if.slave     s_if,
    output logic [N_CH*DATA_W-1:0] ch_data,
    output logic [N_CH-1:0]        ch_stb,
    output logic [N_CH-1:0]        ch_stale,
    output logic                   err_addr,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [LED_W-1:0]       led
);

    localparam int                IDX_W     = ADDR_W + 1;
    localparam int                IDX_SEL_W = ch_idx_w(N_CH);
    localparam logic [AGE_W-1:0]  C_AGE_MAX = AGE_W'(TIMEOUT_TICKS);

    logic                            r_v1;
    logic [ADDR_W-1:0]               r_a1;
    logic [DATA_W-1:0]               r_d1;
    logic [N_CH-1:0][DATA_W-1:0]     r_data;
    logic [N_CH-1:0]                 r_stb;
    logic [N_CH-1:0]                 r_stale;
    logic [N_CH-1:0][AGE_W-1:0]      r_age;
    logic                            r_err;
    logic [ERR_CNT_W-1:0]            r_err_cnt;
    logic                            r_sticky;
    logic                            r_hb;

    logic                            w_xfer;
    logic                            w_tick;
    logic [IDX_W-1:0]                w_idx;
    dec_kind_e                       w_kind;
    logic [N_CH-1:0]                 w_wr;
    logic [N_CH-1:0][AGE_W-1:0]      w_age_nxt;

    assign s_if.s_ready = en;
    assign w_xfer       = s_if.s_valid & en;

    uks_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_a1 <= '0;
            r_d1 <= '0;
        end else begin
            r_v1 <= w_xfer;
            if (w_xfer) begin
                r_a1 <= s_if.s_addr;
                r_d1 <= s_if.s_data;
            end
        end
    end

    // Extra index bit turns addresses below CH_BASE into a negative result.
    assign w_idx = {1'b0, r_a1} - IDX_W'(CH_BASE);

    always_comb begin
        w_kind = DEC_NONE;
        w_wr   = '0;
        if (r_v1) begin
            if (r_a1 == BCAST_ADDR) begin
                w_kind = DEC_BCAST;
                w_wr   = '1;
            end else if (!w_idx[IDX_W-1] && (w_idx < IDX_W'(N_CH))) begin
                w_kind = DEC_CHAN;
                w_wr[w_idx[IDX_SEL_W-1:0]] = 1'b1;
            end else begin
                w_kind = DEC_ERR;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_age_nxt[i] = r_age[i];
            if (w_wr[i]) begin
                w_age_nxt[i] = '0;
            end else if (w_tick && (r_age[i] != C_AGE_MAX)) begin
                w_age_nxt[i] = r_age[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_stb   <= '0;
            r_age   <= '0;
            r_stale <= '0;
        end else begin
            r_stb <= w_wr;
            r_age <= w_age_nxt;
            for (int i = 0; i < N_CH; i++) begin
                if (w_wr[i]) begin
                    r_data[i] <= r_d1;
                end
                r_stale[i] <= (w_age_nxt[i] == C_AGE_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
            r_sticky  <= 1'b0;
            r_hb      <= 1'b0;
        end else begin
            r_err <= (w_kind == DEC_ERR);
            if (w_kind == DEC_ERR) begin
                r_sticky <= 1'b1;
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                end
            end
            if (w_tick) begin
                r_hb <= ~r_hb;
            end
        end
    end

    assign ch_data  = r_data;
    assign ch_stb   = r_stb;
    assign ch_stale = r_stale;
    assign err_addr = r_err;
    assign err_cnt  = r_err_cnt;

    always_comb begin
        led            = '0;
        led[LED_HB]    = r_hb;
        led[LED_STALE] = |r_stale;
        led[LED_ERR]   = r_sticky;
    end

endmodule

`default_nettype wire

// File: tb/tb_uks_channel_demux.sv
// ============================================================================
// tb_uks_channel_demux : vectors, corner sequences and random traffic (rev 1.0)
// ============================================================================
`default_nettype none

module tb_uks_channel_demux;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam int TK   = 4;
    localparam int TO   = 3;
    localparam int BASE = 8;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [N*DW-1:0] ch_data;
    logic [N-1:0]    ch_stb;
    logic [N-1:0]    ch_stale;
    logic            err_addr;
    logic [7:0]      err_cnt;
    logic [4:0]      led;

    uks_channel_demux_if #(.ADDR_W(AW), .DATA_W(DW)) s_if ();

    uks_channel_demux #(
        .N_CH(N), .DATA_W(DW), .ADDR_W(AW), .CH_BASE(BASE), .BCAST_ADDR(8'hFF),
        .TICK_CYCLES(TK), .TIMEOUT_TICKS(TO), .LED_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .s_if(s_if),
        .ch_data(ch_data), .ch_stb(ch_stb), .ch_stale(ch_stale),
        .err_addr(err_addr), .err_cnt(err_cnt), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, expressed as what should be visible after each edge.
    logic [15:0] m_data [N];
    int          m_age  [N];
    logic [3:0]  m_stb, m_stale;
    bit          m_err, m_sticky, m_hb, cur_en;
    int          m_cnt, cyc;
    bit          p_v;
    int          p_a;
    logic [15:0] p_d;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_data[i] = '0;
            m_age[i]  = 0;
        end
        m_stb = '0; m_stale = '0; m_err = 0; m_sticky = 0; m_hb = 0;
        m_cnt = 0; cyc = 0; p_v = 0; p_a = 0; p_d = '0; cur_en = 0;
    endtask

    task automatic model_step(input bit en_i, input bit v_i, input int a_i, input logic [15:0] d_i);
        bit         tk;
        logic [3:0] mask;
        tk    = (cyc % TK) == (TK - 1);
        mask  = '0;
        m_err = 0;
        if (p_v) begin
            if (p_a == 255)                          mask = 4'hF;
            else if (p_a >= BASE && p_a < BASE + N)  mask[p_a - BASE] = 1'b1;
            else begin
                m_err    = 1;
                m_sticky = 1;
                m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                m_data[i] = p_d;
                m_age[i]  = 0;
            end else if (tk) begin
                m_age[i] = (m_age[i] + 1 > TO) ? TO : m_age[i] + 1;
            end
            m_stale[i] = (m_age[i] == TO);
        end
        m_stb = mask;
        if (tk) m_hb = ~m_hb;
        p_v = en_i && v_i;
        p_a = a_i;
        p_d = d_i;
        cyc++;
    endtask

    task automatic compare_model();
        logic [63:0] flat;
        flat = {m_data[3], m_data[2], m_data[1], m_data[0]};
        chk("ch_data",  ch_data,  flat);
        chk("ch_stb",   ch_stb,   m_stb);
        chk("ch_stale", ch_stale, m_stale);
        chk("err_addr", err_addr, m_err);
        chk("err_cnt",  err_cnt,  m_cnt);
        chk("led",      led,      {2'b00, m_sticky, |m_stale, m_hb});
        chk("s_ready",  s_if.s_ready, cur_en);
    endtask

    task automatic wait_cmp();
        @(negedge clk);
        compare_model();
    endtask

    task automatic drive(input bit en_i, input bit v_i, input int a_i, input logic [15:0] d_i);
        en            = en_i;
        s_if.s_valid  = v_i;
        s_if.s_addr   = 8'(a_i);
        s_if.s_data   = d_i;
        cur_en        = en_i;
        model_step(en_i, v_i, a_i, d_i);
    endtask

    task automatic idle_inputs();
        en = 0; s_if.s_valid = 0; s_if.s_addr = '0; s_if.s_data = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        drive(0, 0, 0, 16'h0);
    endtask

    typedef struct {
        int          addr;
        logic [15:0] data;
        logic [3:0]  stb;
        bit          err;
        int          ch;
        logic [15:0] val;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{9,   16'hA5A5, 4'b0010, 1'b0, 1, 16'hA5A5};
        vecs[1] = '{8,   16'h1234, 4'b0001, 1'b0, 0, 16'h1234};
        vecs[2] = '{11,  16'hBEEF, 4'b1000, 1'b0, 3, 16'hBEEF};
        vecs[3] = '{12,  16'hDEAD, 4'b0000, 1'b1, 3, 16'hBEEF};
        vecs[4] = '{7,   16'h0001, 4'b0000, 1'b1, 0, 16'h1234};
        vecs[5] = '{255, 16'h00C3, 4'b1111, 1'b0, 2, 16'h00C3};
        vecs[6] = '{10,  16'h5A5A, 4'b0100, 1'b0, 2, 16'h5A5A};

        rst_n = 1'b0;
        idle_inputs();
        #12;
        model_reset();
        compare_model();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 16'h0);

        // Single writes: strobe and data one edge after acceptance.
        for (int i = 0; i < 7; i++) begin
            wait_cmp(); drive(1, 1, vecs[i].addr, vecs[i].data);
            wait_cmp(); drive(1, 0, 0, 16'h0);
            wait_cmp();
            chk("vec_stb", ch_stb, vecs[i].stb);
            chk("vec_err", err_addr, vecs[i].err);
            chk("vec_val", ch_data[vecs[i].ch*DW +: DW], vecs[i].val);
            if (i == 0) chk("vec0_others", ch_data, 64'h0000_0000_A5A5_0000);
            if (vecs[i].stb == 4'hF) chk("bcast_all", ch_data, {4{vecs[i].val}});
            drive(1, 0, 0, 16'h0);
        end

        // Back-to-back writes to channel 0.
        wait_cmp(); drive(1, 1, 8, 16'h1111);
        wait_cmp(); drive(1, 1, 8, 16'h2222);
        wait_cmp(); chk("b2b_stb1", ch_stb[0], 1'b1); drive(1, 0, 0, 16'h0);
        wait_cmp(); chk("b2b_stb2", ch_stb[0], 1'b1);
        chk("b2b_last", ch_data[15:0], 16'h2222); drive(1, 0, 0, 16'h0);
        wait_cmp(); chk("b2b_end", ch_stb, 4'b0000); drive(1, 0, 0, 16'h0);

        // Enable dropped with a word already captured.
        wait_cmp(); drive(1, 1, 9, 16'h7777);
        wait_cmp(); drive(0, 1, 10, 16'h8888);
        #1 chk("en_ready", s_if.s_ready, 1'b0);
        wait_cmp(); chk("en_inflight", ch_stb, 4'b0010); drive(0, 1, 10, 16'h8888);
        wait_cmp(); chk("en_blocked", ch_stb, 4'b0000); drive(0, 0, 0, 16'h0);

        // Bad addresses until the counter saturates.
        wait_cmp(); drive(1, 1, 7, 16'h0);
        wait_cmp(); drive(1, 1, 12, 16'h0);
        for (int i = 0; i < 300; i++) begin
            int a;
            a = ($urandom % 2 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(12, 254));
            wait_cmp(); drive(1, 1, a, 16'($urandom));
        end
        wait_cmp(); drive(1, 0, 0, 16'h0);
        wait_cmp(); drive(1, 0, 0, 16'h0);
        wait_cmp();
        chk("err_sat", err_cnt, 8'd255);
        chk("err_sticky", led[2], 1'b1);
        drive(1, 0, 0, 16'h0);

        // Staleness from a fresh reset with no writes.
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            wait_cmp();
            if (i == 10) chk("stale_before", ch_stale, 4'b0000);
            drive(0, 0, 0, 16'h0);
        end
        wait_cmp();
        chk("stale_at12", ch_stale, 4'b1111);
        chk("stale_led", led[1], 1'b1);
        drive(1, 0, 0, 16'h0);
        wait_cmp(); drive(1, 0, 0, 16'h0);
        wait_cmp(); drive(1, 1, 10, 16'h0BEE);
        wait_cmp(); drive(1, 0, 0, 16'h0);
        wait_cmp();
        chk("tick_write_stale", ch_stale, 4'b1011);
        chk("tick_write_stb", ch_stb, 4'b0100);
        drive(1, 0, 0, 16'h0);
        repeat (14) begin wait_cmp(); drive(1, 0, 0, 16'h0); end

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            int sel, a;
            sel = $urandom % 8;
            a   = (sel == 0) ? 255 : (sel == 1) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(6, 13));
            wait_cmp();
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, a, 16'($urandom));
        end

        // Asynchronous reset with a word sitting in stage 1.
        wait_cmp(); drive(1, 1, 9, 16'hCAFE);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_data",  ch_data, 64'h0);
        chk("arst_stb",   ch_stb, 4'h0);
        chk("arst_stale", ch_stale, 4'h0);
        chk("arst_cnt",   err_cnt, 8'h0);
        chk("arst_led",   led, 5'h0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 16'h0);
        repeat (3) begin wait_cmp(); drive(0, 0, 0, 16'h0); end
        wait_cmp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
